iterative_alu: RTL and testbench



---
 rtl/iterative_alu_if.sv | 32 +++
 rtl/iterative_alu.sv | 123 ++++++++++++
 tb/tb_iterative_alu.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_alu_if.sv
// Handshake bundle between the CPU controller and the iterative ALU execute stage.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready on the issue side, out_valid/out_ready on the result side.
// Ports: flush, in_valid/in_ready, alu_op, in_a, in_b (issue side);
//        out_valid/out_ready, result, zero, busy (result side).
interface iterative_alu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    // ALU side
    modport slave (
        input  flush, in_valid, alu_op, in_a, in_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );

    // Controller side
    modport master (
        output flush, in_valid, alu_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU execute stage: add/sub/logic in one cycle, shifts one bit per cycle.
// Latency: max(1, n) cycles from accept to out_valid (n = shift amount, 1 for non-shift ops).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports: clk, reset_n (async active-low); bus (slave modport of iterative_alu_if).
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    iterative_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_shreg;
    logic [SHAMT_W-1:0] r_count;
    logic               r_left;
    logic               r_out_valid;
    logic               r_busy;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_left;
    logic [WIDTH-1:0]   w_a_step;
    logic [WIDTH-1:0]   w_sh_step;
    logic [WIDTH-1:0]   w_alu;

    assign w_shamt    = bus.in_b[SHAMT_W-1:0];
    assign w_is_shift = (bus.alu_op == OP_SLL) || (bus.alu_op == OP_SRL);
    assign w_left     = (bus.alu_op == OP_SLL);

    // The first bit of a shift is applied at the accept edge, so an n-bit
    // shift needs n-1 further edges and the latency comes out as max(1, n).
    assign w_a_step  = w_left ? (bus.in_a << 1) : (bus.in_a >> 1);
    assign w_sh_step = r_left ? (r_shreg << 1) : (r_shreg >> 1);

    // Single-cycle result; for shifts this is only used when n <= 1.
    always_comb begin
        w_alu = '0;
        case (bus.alu_op)
            OP_ADD:         w_alu = bus.in_a + bus.in_b;
            OP_SUB:         w_alu = bus.in_a - bus.in_b;
            OP_AND:         w_alu = bus.in_a & bus.in_b;
            OP_OR:          w_alu = bus.in_a | bus.in_b;
            OP_XOR:         w_alu = bus.in_a ^ bus.in_b;
            OP_SLL, OP_SRL: w_alu = (w_shamt == '0) ? bus.in_a : w_a_step;
            default:        w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_shreg     <= '0;
            r_count     <= '0;
            r_left      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.flush) begin
            // Abort wins over accept and output handshake; result keeps its last value.
            r_state     <= IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_busy <= 1'b1;
                        if (w_is_shift && (w_shamt > SHAMT_W'(1))) begin
                            r_shreg <= w_a_step;
                            r_count <= w_shamt - SHAMT_W'(1);
                            r_left  <= w_left;
                            r_state <= SHIFT;
                        end else begin
                            r_result    <= w_alu;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_shreg <= w_sh_step;
                    r_count <= r_count - SHAMT_W'(1);
                    if (r_count == SHAMT_W'(1)) begin
                        r_result    <= w_sh_step;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.result    = r_result;
    assign bus.zero      = (r_result == '0);
endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed cases plus randomized ops against a transaction model.
// Latency: the model predicts out_valid max(1, n) cycles after each accept.
// Backpressure: out_ready and flush are driven both directed and at random.
module tb_iterative_alu;
    localparam int W = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    iterative_alu_if #(.WIDTH(W)) bus ();

    iterative_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Literal expectation attached to the op currently being driven.
    bit          lit_en  = 1'b0;
    logic [31:0] lit_res = '0;
    int          lit_lat = 0;

    // Transaction-level model state.
    bit          m_pend     = 1'b0;
    int          m_age      = 0;
    int          m_lat      = 1;
    logic [31:0] m_exp      = '0;
    logic [31:0] m_result   = '0;
    int          m_acc_cnt  = 0;
    bit          m_lit_en   = 1'b0;
    logic [31:0] m_lit_res  = '0;
    int          m_lit_lat  = 0;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b1000: return a ^ b;
            4'b1010: return a << n;
            4'b1011: return a >> n;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(logic [3:0] op, logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        if ((op == 4'b1010 || op == 4'b1011) && n > 1) return n;
        return 1;
    endfunction

    // Model: an accepted op becomes visible m_lat-1 edges later and leaves on out_ready.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend   = 1'b0;
            m_age    = 0;
            m_result = '0;
        end else if (bus.flush) begin
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (m_age >= m_lat - 1 && bus.out_ready) m_pend = 1'b0;
            else m_age++;
        end else if (bus.in_valid) begin
            m_pend    = 1'b1;
            m_age     = 0;
            m_exp     = ref_alu(bus.alu_op, bus.in_a, bus.in_b);
            m_lat     = ref_lat(bus.alu_op, bus.in_b);
            m_lit_en  = lit_en;
            m_lit_res = lit_res;
            m_lit_lat = lit_lat;
            m_acc_cnt++;
        end
        if (m_pend && m_age >= m_lat - 1) m_result = m_exp;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit exp_v;
        exp_v = m_pend && (m_age >= m_lat - 1);
        chk("in_ready",  32'(bus.in_ready),  32'(!m_pend));
        chk("busy",      32'(bus.busy),      32'(m_pend));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        chk("result",    bus.result,         m_result);
        chk("zero",      32'(bus.zero),      32'(m_result == 32'h0));
        if (!reset_n) chk("rst_result", bus.result, 32'h0);
        if (exp_v && m_age == m_lat - 1 && m_lit_en) begin
            chk("lit_result", bus.result, m_lit_res);
            chk("lit_model",  m_exp,      m_lit_res);
            chk("lit_lat",    32'(m_lat), 32'(m_lit_lat));
        end
    end

    // Present an op and hold in_valid until the model records the accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit le, input logic [31:0] lr, input int ll);
        int acc0;
        acc0         = m_acc_cnt;
        bus.alu_op   = op;
        bus.in_a     = a;
        bus.in_b     = b;
        lit_en       = le;
        lit_res      = lr;
        lit_lat      = ll;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && m_acc_cnt == acc0; i++) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        lit_en       = 1'b0;
        // Operands must be ignored after the accept edge.
        bus.alu_op   = 4'($urandom);
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
    endtask

    task automatic wait_idle(input bit rnd);
        for (int c = 0; c < 300 && m_pend; c++) begin
            @(posedge clk); #1;
            if (rnd && c < 100) begin
                bus.out_ready = 1'($urandom);
                bus.flush     = ($urandom_range(0, 39) == 0);
            end else begin
                bus.out_ready = 1'b1;
                bus.flush     = 1'b0;
            end
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [3:0] ops [10];

    initial begin
        int acc0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        ops = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000,
                4'b1010, 4'b1011, 4'b1010, 4'b1011, 4'b0111};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        issue(4'b0000, 32'hFFFF_FFFF, 32'h2,  1'b1, 32'h0000_0001, 1); wait_idle(1'b0);
        issue(4'b0001, 32'd1234,      32'd1234, 1'b1, 32'h0,       1); wait_idle(1'b0);
        issue(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1); wait_idle(1'b0);
        issue(4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0, 1); wait_idle(1'b0);
        issue(4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0, 1); wait_idle(1'b0);
        issue(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0,         1); wait_idle(1'b0);

        // Shifts, including the n = 0 and n = 1 boundaries
        issue(4'b1010, 32'h0000_0001, 32'd5,  1'b1, 32'h0000_0020, 5);  wait_idle(1'b0);
        issue(4'b1011, 32'h8000_0000, 32'd31, 1'b1, 32'h0000_0001, 31); wait_idle(1'b0);
        issue(4'b1011, 32'hDEAD_BEEF, 32'd32, 1'b1, 32'hDEAD_BEEF, 1);  wait_idle(1'b0);
        issue(4'b1010, 32'h0000_0001, 32'd1,  1'b1, 32'h0000_0002, 1);  wait_idle(1'b0);
        issue(4'b1011, 32'h0000_0100, 32'd2,  1'b1, 32'h0000_0040, 2);  wait_idle(1'b0);

        // Backpressure: result held in DONE, second op waits with in_valid high
        bus.out_ready = 1'b0;
        issue(4'b0000, 32'd10, 32'd20, 1'b1, 32'd30, 1);
        bus.alu_op   = 4'b1000;
        bus.in_a     = 32'h1234_5678;
        bus.in_b     = 32'h1234_5678;
        lit_en       = 1'b1;
        lit_res      = 32'h0;
        lit_lat      = 1;
        bus.in_valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        acc0 = m_acc_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && m_acc_cnt == acc0; i++) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        lit_en       = 1'b0;
        wait_idle(1'b0);

        // Flush mid-shift: out_valid must never rise and result keeps its value
        issue(4'b1010, 32'h0000_0003, 32'd10, 1'b0, 32'h0, 0);
        repeat (2) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        repeat (12) begin @(posedge clk); #1; end

        // Flush together with in_valid in IDLE: no accept
        bus.alu_op   = 4'b0000;
        bus.in_a     = 32'd5;
        bus.in_b     = 32'd6;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Asynchronous reset in the middle of a 20-bit shift
        issue(4'b1010, 32'h0000_0001, 32'd20, 1'b0, 32'h0, 0);
        repeat (4) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Randomized ops with random backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  op;
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = 4'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7));
            bus.out_ready = 1'($urandom);
            issue(op, a, b, 1'b0, 32'h0, 0);
            wait_idle(1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
